// File: rtl/control_pkg.sv
// Shared definitions for the hardwired control sequencer.
//
// Contents:
//   - FSM state encoding (T0..T6, HALT) as legacy-compatible constants
//   - opcode constants and the R-format opcode range
//   - instruction-register field positions
//
// Optional feature macro used by the including RTL: ILLEGAL_TRAP_EN.
package control_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_T0   = 3'd0;
    localparam logic [2:0] ST_T1   = 3'd1;
    localparam logic [2:0] ST_T2   = 3'd2;
    localparam logic [2:0] ST_T3   = 3'd3;
    localparam logic [2:0] ST_T4   = 3'd4;
    localparam logic [2:0] ST_T5   = 3'd5;
    localparam logic [2:0] ST_T6   = 3'd6;
    localparam logic [2:0] ST_HALT = 3'd7;

    // Opcodes
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // R-format opcodes occupy RFMT_LO..RFMT_HI inclusive
    localparam logic [4:0] RFMT_LO = 5'b00000;
    localparam logic [4:0] RFMT_HI = 5'b01101;

    // Instruction register field positions (MSB of each field)
    localparam int unsigned IR_OPC_MSB = 31;
    localparam int unsigned IR_RA_MSB  = 26;
    localparam int unsigned IR_RB_MSB  = 22;
    localparam int unsigned IR_RC_MSB  = 18;

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode classifier.
//
// Ports:
//   opcode     in   OPW  IR opcode field
//   is_rfmt    out  1    register-register ALU op
//   is_muldiv  out  1    multiply or divide
//   is_nop     out  1    explicit nop
//   is_halt    out  1    halt
//   is_illegal out  1    none of the above
//   alu_op     out  OPW  ALU operation code (opcode + 1, wrapping)
module opcode_decoder
    import control_pkg::*;
#(
    parameter int unsigned OPW = 5
) (
    input  logic [OPW-1:0] opcode,
    output logic           is_rfmt,
    output logic           is_muldiv,
    output logic           is_nop,
    output logic           is_halt,
    output logic           is_illegal,
    output logic [OPW-1:0] alu_op
);

    always_comb begin
        // RFMT_LO is zero, so only the upper bound needs comparing
        is_rfmt    = (opcode <= OPW'(RFMT_HI));
        is_muldiv  = (opcode == OPW'(OP_MUL)) || (opcode == OPW'(OP_DIV));
        is_nop     = (opcode == OPW'(OP_NOP));
        is_halt    = (opcode == OPW'(OP_HALT));
        is_illegal = !(is_rfmt || is_muldiv || is_nop || is_halt);
        alu_op     = opcode + OPW'(1);
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the single-bus datapath.
//
// Sequences fetch (T0-T2) and execute (T3-T6) for R-format ALU ops,
// mul/div, nop and halt. All outputs decode registered state only.
//
// Ports:
//   Clock, Clear(async, active low), Stop, MemReady, IR[31:0]  inputs
//   Gra/Grb/Grc, Rin/Rout                register select / load / drive
//   PCout..LOin                          datapath strobes
//   Read                                 memory read request
//   OP[OPW-1:0]                          ALU operation (T4-T6 only)
//   Run                                  low in HALT
//   Illegal                              sticky illegal-opcode flag
//
// Optional feature: define ILLEGAL_TRAP_EN to trap undefined opcodes
// (sets Illegal and halts). Without it they behave as nop and Illegal=0.
module control_sequencer
    import control_pkg::*;
#(
    parameter int unsigned OPW = 5,
    parameter int unsigned RFW = 4
) (
    input  logic           Clock,
    input  logic           Clear,
    input  logic           Stop,
    input  logic           MemReady,
    input  logic [31:0]    IR,
    output logic           Gra,
    output logic           Grb,
    output logic           Grc,
    output logic           Rin,
    output logic           Rout,
    output logic           PCout,
    output logic           PCin,
    output logic           IncPC,
    output logic           MARin,
    output logic           MDRin,
    output logic           MDRout,
    output logic           IRin,
    output logic           Yin,
    output logic           ZLowin,
    output logic           ZHighin,
    output logic           ZLowout,
    output logic           ZHighout,
    output logic           HIin,
    output logic           LOin,
    output logic           Read,
    output logic [OPW-1:0] OP,
    output logic           Run,
    output logic           Illegal
);

    logic [2:0]     state_q;
    logic [2:0]     state_d;
    // Low for the first cycle after Clear so the reset cycle drives no strobes
    logic           primed_q;
    logic           first_t1_q;
    logic           muldiv_q;
    logic [OPW-1:0] op_q;

    logic           dec_rfmt;
    logic           dec_muldiv;
    logic           dec_nop;
    logic           dec_halt;
    logic           dec_illegal;
    logic [OPW-1:0] dec_op;

    // Register fields are consumed by the select/encode logic, not here
    logic unused_ir_fields;
    assign unused_ir_fields = ^{IR[IR_OPC_MSB-OPW -: 3*RFW], IR[IR_OPC_MSB-OPW-3*RFW:0]};

    opcode_decoder #(
        .OPW(OPW)
    ) u_decoder (
        .opcode    (IR[IR_OPC_MSB -: OPW]),
        .is_rfmt   (dec_rfmt),
        .is_muldiv (dec_muldiv),
        .is_nop    (dec_nop),
        .is_halt   (dec_halt),
        .is_illegal(dec_illegal),
        .alu_op    (dec_op)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_T0: state_d = ST_T1;
            ST_T1: if (MemReady) state_d = ST_T2;
            ST_T2: state_d = ST_T3;
            ST_T3: begin
                if (dec_halt)
                    state_d = ST_HALT;
                else if (dec_rfmt || dec_muldiv)
                    state_d = ST_T4;
`ifdef ILLEGAL_TRAP_EN
                else if (dec_illegal)
                    state_d = ST_HALT;
                else if (dec_nop)
                    state_d = Stop ? ST_HALT : ST_T0;
`else
                else if (dec_nop || dec_illegal)
                    state_d = Stop ? ST_HALT : ST_T0;
`endif
            end
            ST_T4: state_d = ST_T5;
            ST_T5: begin
                if (muldiv_q)
                    state_d = ST_T6;
                else
                    state_d = Stop ? ST_HALT : ST_T0;
            end
            ST_T6:   state_d = Stop ? ST_HALT : ST_T0;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_T0;
        endcase
        if (!primed_q) state_d = ST_T0;
    end

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q    <= ST_T0;
            primed_q   <= 1'b0;
            first_t1_q <= 1'b0;
            muldiv_q   <= 1'b0;
            op_q       <= '0;
        end else begin
            state_q    <= state_d;
            primed_q   <= 1'b1;
            first_t1_q <= (state_d == ST_T1) && (state_q != ST_T1);
            if (primed_q && state_q == ST_T3) begin
                muldiv_q <= dec_muldiv;
                op_q     <= (dec_rfmt || dec_muldiv) ? dec_op : '0;
            end else if (state_d == ST_T0 || state_d == ST_HALT) begin
                op_q <= '0;
            end
        end
    end

`ifdef ILLEGAL_TRAP_EN
    logic illegal_q;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear)
            illegal_q <= 1'b0;
        else if (primed_q && state_q == ST_T3 && dec_illegal)
            illegal_q <= 1'b1;
    end

    assign Illegal = illegal_q;
`else
    assign Illegal = 1'b0;
`endif

    assign OP  = op_q;
    assign Run = (state_q != ST_HALT);

    // Strobe decode from registered state
    always_comb begin
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowin   = 1'b0;
        ZHighin  = 1'b0;
        ZLowout  = 1'b0;
        ZHighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Read     = 1'b0;
        if (primed_q) begin
            case (state_q)
                ST_T0: begin
                    PCout  = 1'b1;
                    MARin  = 1'b1;
                    IncPC  = 1'b1;
                    ZLowin = 1'b1;
                end
                ST_T1: begin
                    ZLowout = 1'b1;
                    PCin    = first_t1_q;
                    Read    = 1'b1;
                    MDRin   = 1'b1;
                end
                ST_T2: begin
                    MDRout = 1'b1;
                    IRin   = 1'b1;
                end
                ST_T3: begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end
                ST_T4: begin
                    Rout   = 1'b1;
                    ZLowin = 1'b1;
                    if (muldiv_q) begin
                        Gra     = 1'b1;
                        ZHighin = 1'b1;
                    end else begin
                        Grc = 1'b1;
                    end
                end
                ST_T5: begin
                    ZLowout = 1'b1;
                    if (muldiv_q) begin
                        LOin = 1'b1;
                    end else begin
                        Gra = 1'b1;
                        Rin = 1'b1;
                    end
                end
                ST_T6: begin
                    ZHighout = 1'b1;
                    HIin     = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. A behavioural model expands
// each instruction into its expected per-cycle strobe trace, which is then
// compared against the DUT one cycle at a time.
module tb_control_sequencer;

    logic        Clock;
    logic        Clear;
    logic        Stop;
    logic        MemReady;
    logic [31:0] IR;
    logic Gra, Grb, Grc, Rin, Rout, PCout, PCin, IncPC, MARin, MDRin, MDRout;
    logic IRin, Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin, Read;
    logic [4:0]  OP;
    logic        Run;
    logic        Illegal;

    control_sequencer #(.OPW(5), .RFW(4)) dut (
        .Clock(Clock), .Clear(Clear), .Stop(Stop), .MemReady(MemReady), .IR(IR),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowin(ZLowin), .ZHighin(ZHighin),
        .ZLowout(ZLowout), .ZHighout(ZHighout), .HIin(HIin), .LOin(LOin),
        .Read(Read), .OP(OP), .Run(Run), .Illegal(Illegal)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    localparam logic [19:0] S_GRA      = 20'd1 << 19;
    localparam logic [19:0] S_GRB      = 20'd1 << 18;
    localparam logic [19:0] S_GRC      = 20'd1 << 17;
    localparam logic [19:0] S_RIN      = 20'd1 << 16;
    localparam logic [19:0] S_ROUT     = 20'd1 << 15;
    localparam logic [19:0] S_PCOUT    = 20'd1 << 14;
    localparam logic [19:0] S_PCIN     = 20'd1 << 13;
    localparam logic [19:0] S_INCPC    = 20'd1 << 12;
    localparam logic [19:0] S_MARIN    = 20'd1 << 11;
    localparam logic [19:0] S_MDRIN    = 20'd1 << 10;
    localparam logic [19:0] S_MDROUT   = 20'd1 << 9;
    localparam logic [19:0] S_IRIN     = 20'd1 << 8;
    localparam logic [19:0] S_YIN      = 20'd1 << 7;
    localparam logic [19:0] S_ZLOWIN   = 20'd1 << 6;
    localparam logic [19:0] S_ZHIGHIN  = 20'd1 << 5;
    localparam logic [19:0] S_ZLOWOUT  = 20'd1 << 4;
    localparam logic [19:0] S_ZHIGHOUT = 20'd1 << 3;
    localparam logic [19:0] S_HIIN     = 20'd1 << 2;
    localparam logic [19:0] S_LOIN     = 20'd1 << 1;
    localparam logic [19:0] S_READ     = 20'd1 << 0;

    logic [26:0] obs;
    assign obs = {Gra, Grb, Grc, Rin, Rout, PCout, PCin, IncPC, MARin, MDRin,
                  MDRout, IRin, Yin, ZLowin, ZHighin, ZLowout, ZHighout, HIin,
                  LOin, Read, OP, Run, Illegal};

    typedef struct {
        logic [26:0] exp;
        logic        mr;
        logic        stp;
        string       tag;
    } vec_t;

    vec_t        q[$];
    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    int unsigned instr_no    = 0;
    logic        ill_model   = 1'b0;

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic undefined_op(input logic [4:0] opc);
        return !(opc <= 5'd13 || opc == 5'd15 || opc == 5'd16 ||
                 opc == 5'd26 || opc == 5'd27);
    endfunction

    task automatic check(input string tag, input logic [26:0] o, input logic [26:0] e);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL %s observed=%07h expected=%07h", tag, o, e);
        end
    endtask

    task automatic push(input logic [19:0] s, input logic [4:0] op, input logic run,
                        input logic mr, input logic stp, input string phase);
        vec_t v;
        v.exp = {s, op, run, ill_model};
        v.mr  = mr;
        v.stp = stp;
        v.tag = $sformatf("i%0d_%s", instr_no, phase);
        q.push_back(v);
    endtask

    // Drive one cycle's inputs, compare outputs, advance to #1 after next edge
    task automatic step(input vec_t v);
        MemReady = v.mr;
        Stop     = v.stp;
        check(v.tag, obs, v.exp);
        @(posedge Clock);
        #1;
    endtask

    task automatic drain();
        while (q.size() > 0) step(q.pop_front());
    endtask

    // Expected trace of one instruction; halts reports whether it ends in HALT
    task automatic model_instr(input logic [4:0] opc, input int unsigned waits,
                               input logic stop_last, output logic halts);
        logic       rf, md, hl, ud;
        logic [4:0] op;
        rf = (opc <= 5'd13);
        md = (opc == 5'd15) || (opc == 5'd16);
        hl = (opc == 5'd27);
        ud = undefined_op(opc);
        op = opc + 5'd1;
        halts = 1'b0;
        instr_no++;
        push(S_PCOUT | S_MARIN | S_INCPC | S_ZLOWIN, 5'd0, 1'b1, rbit(), rbit(), "T0");
        for (int unsigned k = 0; k <= waits; k++)
            push(S_ZLOWOUT | S_READ | S_MDRIN | ((k == 0) ? S_PCIN : 20'd0),
                 5'd0, 1'b1, (k == waits), rbit(), "T1");
        push(S_MDROUT | S_IRIN, 5'd0, 1'b1, rbit(), rbit(), "T2");
        if (rf || md) begin
            push(S_GRB | S_ROUT | S_YIN, 5'd0, 1'b1, rbit(), rbit(), "T3");
            if (rf) begin
                push(S_GRC | S_ROUT | S_ZLOWIN, op, 1'b1, rbit(), rbit(), "T4");
                push(S_ZLOWOUT | S_GRA | S_RIN, op, 1'b1, rbit(), stop_last, "T5");
            end else begin
                push(S_GRA | S_ROUT | S_ZLOWIN | S_ZHIGHIN, op, 1'b1, rbit(), rbit(), "T4");
                push(S_ZLOWOUT | S_LOIN, op, 1'b1, rbit(), rbit(), "T5");
                push(S_ZHIGHOUT | S_HIIN, op, 1'b1, rbit(), stop_last, "T6");
            end
            halts = stop_last;
        end else begin
            push(S_GRB | S_ROUT | S_YIN, 5'd0, 1'b1, rbit(), stop_last, "T3");
            halts = hl || stop_last;
`ifdef ILLEGAL_TRAP_EN
            if (ud) begin
                halts     = 1'b1;
                ill_model = 1'b1;
            end
`else
            if (ud) halts = stop_last;
`endif
        end
    endtask

    task automatic push_halt(input int unsigned n);
        for (int unsigned k = 0; k < n; k++)
            push(20'd0, 5'd0, 1'b0, rbit(), rbit(), "HALT");
    endtask

    task automatic run_ir(input logic [31:0] ir, input int unsigned waits, input logic stop_last);
        logic h;
        IR = ir;
        model_instr(ir[31:27], waits, stop_last, h);
        if (h) push_halt(4);
        drain();
    endtask

    task automatic run_op(input logic [4:0] opc, input int unsigned waits, input logic stop_last);
        run_ir({opc, 27'($urandom)}, waits, stop_last);
    endtask

    // Called at #1 after a rising edge; leaves the DUT in its first primed T0
    task automatic do_reset();
        vec_t v;
        Clear = 1'b0;
        #1;
        ill_model = 1'b0;
        check("reset", obs, {20'd0, 5'd0, 1'b1, 1'b0});
        @(posedge Clock);
        #1;
        check("reset_hold", obs, {20'd0, 5'd0, 1'b1, 1'b0});
        Clear = 1'b1;
        v.exp = {20'd0, 5'd0, 1'b1, 1'b0};
        v.mr  = rbit();
        v.stp = rbit();
        v.tag = "post_reset";
        step(v);
    endtask

    initial begin
        vec_t       v;
        logic       h;
        logic [4:0] opc;
        Clear    = 1'b0;
        Stop     = 1'b0;
        MemReady = 1'b0;
        IR       = '0;
        @(posedge Clock);
        #1;
        do_reset();

        run_ir(32'h5B320000, 0, 1'b0);      // rol R6, R6, R4
        run_op(5'b00011, 3, 1'b0);          // memory wait of 3 cycles
        run_op(5'b01111, 2, 1'b0);          // mul
        run_op(5'b10000, 0, 1'b0);          // div
        run_op(5'b11010, 1, 1'b0);          // nop
        run_op(5'b01101, 0, 1'b0);          // top of R-format range
        run_op(5'b00000, 0, 1'b0);          // bottom of R-format range
`ifndef ILLEGAL_TRAP_EN
        run_op(5'b11111, 0, 1'b0);          // undefined acts as nop
        run_op(5'b01110, 1, 1'b0);
`endif

        for (int i = 0; i < 30; i++) begin
            do begin
                opc = 5'($urandom_range(0, 31));
`ifdef ILLEGAL_TRAP_EN
            end while (opc == 5'd27 || undefined_op(opc));
`else
            end while (opc == 5'd27);
`endif
            run_op(opc, $urandom_range(0, 3), 1'b0);
        end

        run_op(5'b00101, 0, 1'b1);          // Stop at R-format T5
        do_reset();

        // Clear asserted in the middle of a mul T4
        IR = {5'b01111, 27'($urandom)};
        model_instr(5'b01111, 1, 1'b0, h);
        repeat (5) step(q.pop_front());
        v = q.pop_front();
        check(v.tag, obs, v.exp);
        #2;
        q.delete();
        do_reset();

        run_op(5'b11011, 0, 1'b0);          // halt
        do_reset();
        run_op(5'b11010, 2, 1'b1);          // Stop at nop T3
        do_reset();
        run_op(5'b10000, 1, 1'b1);          // Stop at div T6
        do_reset();
`ifdef ILLEGAL_TRAP_EN
        run_op(5'b11111, 0, 1'b0);          // trap: Illegal set, HALT
        do_reset();
        run_ir(32'h5B320000, 0, 1'b0);      // Illegal cleared by Clear
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired control unit that drives the single-bus datapath's strobes from the instruction register.
- Sequences fetch (T0–T2) and execute (T3–T6) for register-register ALU ops, multiply/divide, nop and halt.
- Replaces bench-driven strobe sequencing.
- Sits beside the datapath: consumes IR and memory-ready, emits all load/drive/select/ALU-op controls.

Parameters:
- OPW, 5, opcode width (IR[31:27]).
- RFW, 4, register-field width (Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]).

Ports:
- Clock  in  1  system clock, rising edge.
- Clear  in  1  asynchronous active-low reset.
- Stop  in  1  request halt after current instruction.
- MemReady  in  1  memory read data valid.
- IR  in  32  instruction register contents.
- Gra, Grb, Grc  out  1 each  register-field select to select/encode logic.
- Rin, Rout  out  1 each  load/drive the selected register.
- PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes.
- ZLowin, ZHighin, ZLowout, ZHighout, HIin, LOin  out  1 each  datapath strobes.
- Read  out  1  memory read request.
- OP  out  5  ALU operation.
- Run  out  1  high while executing, low in HALT.
- Illegal  out  1  sticky illegal-opcode flag (ILLEGAL_TRAP_EN only; else tied 0).

Behaviour:
- Moore FSM; every output is registered-state decode, no combinational path from inputs except via the state register.
- Clear low, asynchronous: state=T0, every strobe 0, OP=0, Run=1, Illegal=0.
- Reset mid-operation aborts the instruction with no partial writeback.
- States and per-state outputs:
  - T0: PCout, MARin, IncPC, ZLowin.
  - T1: ZLowout, PCin, Read, MDRin. Holds in T1 while MemReady=0, keeping Read/MDRin high. PCin pulses only on the first T1 cycle.
  - T2: MDRout, IRin.
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout (R-format) or Gra, Rout (mul/div); OP valid; ZLowin; ZHighin for mul/div.
  - T5: R-format: ZLowout, Gra, Rin, then T0. Mul/div: ZLowout, LOin, then T6.
  - T6: ZHighout, HIin, then T0.
  - HALT: all strobes 0, Run=0.
- Decode on IR sampled in T3:
  - Opcodes 00000–01101: R-format, Ra = Rb op Rc. OP = opcode + 1 (mod 32), e.g. rol 01011 -> OP 01100.
  - 01111 mul, 10000 div: operands Rb (Y) and Ra; OP = opcode + 1.
  - 11010 nop: T3 -> T0.
  - 11011 halt: T3 -> HALT.
  - Other opcodes: nop.
- OP holds its value through T4–T6 and returns to 0 in T0.
- Stop sampled only at the last execute state; if high, go to HALT instead of T0.
- HALT is left only by Clear.
- Fetch latency: 3 cycles plus MemReady wait. R-format total 6 cycles; mul/div 7; nop 4.

Optional Feature:
- ILLEGAL_TRAP_EN
  - Defined: an undefined opcode in T3 sets Illegal (sticky until Clear) and goes to HALT with no register write.
  - Undefined: treated as nop; Illegal is constant 0.

Decomposition:
- Package control_pkg: state enum (T0..T6, HALT); opcode constants (OP_ROL=5'b01011, OP_MUL, OP_DIV, OP_NOP, OP_HALT); R-format range bounds; IR field bit positions.
- One sub-module, opcode_decoder: combinational IR[31:27] -> {is_rfmt, is_muldiv, is_nop, is_halt, is_illegal, alu_op}.

Test Plan:
- Reset: Clear low mid-T4 -> state T0, all strobes 0 the same cycle; Run=1 after release.
- ROL: IR=32'h5B320000, MemReady=1 -> T3 Grb/Rout/Yin (R6), T4 Grc/Rout (R4) with OP=01100, T5 ZLowout+Gra+Rin (R6); back in T0 at cycle 6.
- Memory wait: MemReady low 3 cycles in T1 -> Read/MDRin high 4 cycles; PCin exactly 1 pulse; IRin in the cycle after MemReady rises.
- Mul: opcode 01111 -> T4 asserts ZLowin and ZHighin, T5 LOin, T6 HIin; Rin never asserted.
- Halt/Stop: opcode 11011 -> HALT at cycle 4, Run=0, no further PCout. Stop=1 during R-format T5 -> HALT after writeback.
- Illegal: opcode 11111 -> with ILLEGAL_TRAP_EN: Illegal=1, HALT. Without: nop, returns to T0, Illegal=0.
